// File: rtl/image_dump_uart.sv
`default_nettype none
// ============================================================================
// Module      : image_dump_uart
// Description : Reads a byte-addressed memory region one 16-bit word at a
//               time and streams each word as two 8N1 UART frames, high
//               (even-address) byte first.
// Ports       : clk       - system clock, rising edge
//               rst       - synchronous active-high reset
//               start     - one-cycle dump request (accepted only in IDLE)
//               busy      - dump in progress
//               done      - one-cycle pulse after the last stop bit
//               mem_re    - word read strobe
//               mem_addr  - even byte address of the word being read
//               mem_rdata - {mem[addr], mem[addr+1]}, valid cycle after mem_re
//               txd       - UART serial output, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module image_dump_uart #(
    parameter int          CLK_HZ     = 25000000,
    parameter int          BAUD       = 115200,
    parameter logic [15:0] START_ADDR = 16'hc000,
    parameter logic [15:0] END_ADDR   = 16'hffff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        mem_re,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic        txd
);

    localparam int          c_div       = CLK_HZ / BAUD;
    localparam int          c_cnt_w     = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(c_div - 1);
    // Last word address; termination is an equality test so a region ending
    // at 16'hffff never relies on the counter wrapping to zero.
    localparam logic [15:0] c_last_addr = END_ADDR & 16'hfffe;
    localparam logic        c_empty     = (START_ADDR > END_ADDR);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_READ    = 3'd1;
    localparam logic [2:0] c_CAPTURE = 3'd2;
    localparam logic [2:0] c_SEND_HI = 3'd3;
    localparam logic [2:0] c_SEND_LO = 3'd4;
    localparam logic [2:0] c_DONE    = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [15:0]        r_addr;
    logic [15:0]        r_word;
    logic [c_cnt_w-1:0] r_cnt;
    logic [3:0]         r_bit;    // 0 = start bit, 1..8 = data, 9 = stop bit

    logic               w_bit_end;
    logic               w_frame_end;
    logic [7:0]         w_tx_byte;
    logic [2:0]         w_idx;
    logic               w_tx_bit;

    assign w_bit_end   = (r_cnt == c_cnt_max);
    assign w_frame_end = w_bit_end && (r_bit == 4'd9);
    assign w_tx_byte   = (r_state == c_SEND_LO) ? r_word[7:0] : r_word[15:8];
    assign w_idx       = 3'(r_bit - 4'd1);
    assign mem_addr    = r_addr;

    // Serial bit is a pure function of registered state, so neither start
    // nor mem_rdata can reach txd combinationally.
    always_comb begin
        w_tx_bit = 1'b1;
        case (r_bit)
            4'd0:    w_tx_bit = 1'b0;
            4'd9:    w_tx_bit = 1'b1;
            default: w_tx_bit = w_tx_byte[w_idx];
        endcase
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        mem_re = 1'b0;
        txd    = 1'b1;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next = c_empty ? c_DONE : c_READ;
                end
            end
            c_READ: begin
                busy   = 1'b1;
                mem_re = 1'b1;
                w_next = c_CAPTURE;
            end
            c_CAPTURE: begin
                busy   = 1'b1;
                w_next = c_SEND_HI;
            end
            c_SEND_HI: begin
                busy = 1'b1;
                txd  = w_tx_bit;
                if (w_frame_end) begin
                    w_next = c_SEND_LO;
                end
            end
            c_SEND_LO: begin
                busy = 1'b1;
                txd  = w_tx_bit;
                if (w_frame_end) begin
                    w_next = (r_addr == c_last_addr) ? c_DONE : c_READ;
                end
            end
            c_DONE: begin
                done   = 1'b1;
                w_next = c_IDLE;
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_addr  <= 16'h0000;
            r_word  <= 16'h0000;
            r_cnt   <= '0;
            r_bit   <= 4'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_addr <= START_ADDR;
                    end
                end
                c_CAPTURE: begin
                    r_word <= mem_rdata;
                    r_cnt  <= '0;
                    r_bit  <= 4'd0;
                end
                c_SEND_HI, c_SEND_LO: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        r_bit <= (r_bit == 4'd9) ? 4'd0 : r_bit + 4'd1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                    if ((r_state == c_SEND_LO) && w_frame_end && (r_addr != c_last_addr)) begin
                        r_addr <= r_addr + 16'd2;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
